// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the remote_comm command link.
package remote_comm_pkg;

  // 50 MHz clock / 19200 baud
  localparam int unsigned BaudDivDefault = 2604;

  // Top-level command FSM: one 16-bit word goes out as two back-to-back bytes
  typedef enum logic [1:0] {
    StIdle,
    StSendHi,
    StSendLo
  } top_state_e;

  // Per-byte UART bit FSM, shared by the transmit and receive halves
  typedef enum logic [1:0] {
    UartIdle,
    UartStart,
    UartData,
    UartStop
  } uart_state_e;

endpackage

// File: rtl/remote_comm_uart.sv
// Byte-level UART: 8N1 serializer and mid-bit sampling deserializer.
// The receive half is built only when REMOTE_COMM_RX_EN is defined; otherwise
// rx_data/rx_rdy are tied low and rx/clr_rdy are ignored.
module uart
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BaudDivDefault
) (
  input  logic       clk,
  input  logic       rst,
  // transmit handshake
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx,
  // receive handshake
  input  logic       rx,
  input  logic       clr_rdy,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CntW-1:0] BitLast = CntW'(BAUD_DIV - 1);

  // ---------------------------------------------------------------------------
  // Transmit
  // ---------------------------------------------------------------------------
  uart_state_e     tx_state_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [2:0]      tx_bit_q;
  logic [7:0]      tx_shift_q;
  logic            tx_q;
  logic            tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BitLast);
  // Asserted during the last clock of the stop bit so a chained byte starts with no gap
  assign tx_done    = (tx_state_q == UartStop) && tx_bit_end;
  assign tx         = tx_q;

  // Transmit bit FSM; trmt is honoured in idle or in the final stop-bit clock
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= UartIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      if (tx_state_q == UartIdle || tx_bit_end) begin
        tx_cnt_q <= '0;
      end else begin
        tx_cnt_q <= tx_cnt_q + CntW'(1);
      end

      case (tx_state_q)
        UartIdle: begin
          if (trmt) begin
            tx_shift_q <= tx_data;
            tx_q       <= 1'b0;
            tx_state_q <= UartStart;
          end
        end
        UartStart: begin
          if (tx_bit_end) begin
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_bit_q   <= '0;
            tx_state_q <= UartData;
          end
        end
        UartData: begin
          if (tx_bit_end) begin
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= UartStop;
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end
        end
        UartStop: begin
          if (tx_bit_end) begin
            if (trmt) begin
              tx_shift_q <= tx_data;
              tx_q       <= 1'b0;
              tx_state_q <= UartStart;
            end else begin
              tx_q       <= 1'b1;
              tx_state_q <= UartIdle;
            end
          end
        end
        default: begin
          tx_q       <= 1'b1;
          tx_state_q <= UartIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive
  // ---------------------------------------------------------------------------
`ifdef REMOTE_COMM_RX_EN
  localparam logic [CntW-1:0] HalfLast = CntW'(BAUD_DIV / 2 - 1);

  logic            rx_ff1_q, rx_ff2_q, rx_prev_q;
  uart_state_e     rx_state_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;
  logic [7:0]      rx_data_q;
  logic            rx_rdy_q;
  logic            rx_fall;
  logic            rx_sample;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ff1_q  <= 1'b1;
      rx_ff2_q  <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_ff1_q  <= rx;
      rx_ff2_q  <= rx_ff1_q;
      rx_prev_q <= rx_ff2_q;
    end
  end

  assign rx_fall   = rx_prev_q & ~rx_ff2_q;
  // First sample lands mid start bit, the rest one full bit apart
  assign rx_sample = (rx_state_q == UartStart) ? (rx_cnt_q == HalfLast)
                                                : (rx_cnt_q == BitLast);

  // Receive bit FSM; a completed byte's set of rx_rdy overrides a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= UartIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_rdy_q   <= 1'b0;
    end else begin
      if (clr_rdy) begin
        rx_rdy_q <= 1'b0;
      end

      if (rx_state_q == UartIdle || rx_sample) begin
        rx_cnt_q <= '0;
      end else begin
        rx_cnt_q <= rx_cnt_q + CntW'(1);
      end

      case (rx_state_q)
        UartIdle: begin
          if (rx_fall) begin
            rx_rdy_q   <= 1'b0;
            rx_state_q <= UartStart;
          end
        end
        UartStart: begin
          if (rx_sample) begin
            rx_bit_q   <= '0;
            // Line back high at mid start bit: treat as a glitch
            rx_state_q <= rx_ff2_q ? UartIdle : UartData;
          end
        end
        UartData: begin
          if (rx_sample) begin
            rx_shift_q <= {rx_ff2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= UartStop;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end
        end
        UartStop: begin
          if (rx_sample) begin
            // Framing error (stop sampled low) drops the byte silently
            if (rx_ff2_q) begin
              rx_data_q <= rx_shift_q;
              rx_rdy_q  <= 1'b1;
            end
            rx_state_q <= UartIdle;
          end
        end
        default: rx_state_q <= UartIdle;
      endcase
    end
  end

  assign rx_rdy  = rx_rdy_q;
  assign rx_data = rx_data_q;
`else
  logic unused_rx;
  assign unused_rx = rx ^ clr_rdy;
  assign rx_rdy    = 1'b0;
  assign rx_data   = 8'h00;
`endif

endmodule

// File: rtl/remote_comm.sv
// Remote command link: sends a 16-bit command as two UART bytes (high first)
// and reports the last byte received on RX.
// Optional receive path: define REMOTE_COMM_RX_EN to build it.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BaudDivDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_rx_rdy
);

  top_state_e  state_q;
  logic [15:0] cmd_q;
  logic        trmt_q;
  logic        cmd_sent_q;
  logic        trmt;
  logic        tx_done;
  logic [7:0]  tx_data;

  // High byte launches from the registered request; the low byte is chained
  // in the high byte's final stop-bit clock so the two frames abut exactly.
  assign trmt    = trmt_q | ((state_q == StSendHi) & tx_done);
  assign tx_data = trmt_q ? cmd_q[15:8] : cmd_q[7:0];

  // Command FSM: accept in idle only, then sequence high and low bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      trmt_q     <= 1'b0;
      cmd_sent_q <= 1'b0;
    end else begin
      trmt_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (send_cmd) begin
            cmd_q      <= cmd;
            cmd_sent_q <= 1'b0;
            trmt_q     <= 1'b1;
            state_q    <= StSendHi;
          end
        end
        StSendHi: begin
          if (tx_done) begin
            state_q <= StSendLo;
          end
        end
        StSendLo: begin
          if (tx_done) begin
            cmd_sent_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_sent = cmd_sent_q;

  uart #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .tx      (TX),
    .rx      (RX),
    .clr_rdy (clr_rx_rdy),
    .rx_rdy  (resp_rdy),
    .rx_data (resp)
  );

endmodule

// File: tb/tb_remote_comm.sv
// Self-checking bench for remote_comm with a short bit time.
module tb_remote_comm;

  localparam int unsigned B    = 16;
  localparam int unsigned Half = B / 2;
`ifdef REMOTE_COMM_RX_EN
  localparam bit RxEn = 1'b1;
`else
  localparam bit RxEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        TX;
  logic        RX;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_rx_rdy;

  remote_comm #(
    .BAUD_DIV(B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .send_cmd   (send_cmd),
    .cmd_sent   (cmd_sent),
    .TX         (TX),
    .RX         (RX),
    .resp       (resp),
    .resp_rdy   (resp_rdy),
    .clr_rx_rdy (clr_rx_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];   // bytes the spec says must appear on TX, in order
  bit         model_sent; // expected cmd_sent level while idle
  logic [7:0] m_resp;
  bit         m_rdy;

  // Receive model: start clears ready, a good stop bit delivers the byte
  task automatic rx_model(input logic [7:0] d, input bit stop);
    m_rdy = 1'b0;
    if (stop && RxEn) begin
      m_resp = d;
      m_rdy  = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // TX line decoder: behavioural UART receiver sampling at mid-bit
  // ---------------------------------------------------------------------------
  logic [7:0] mon_q[$];
  int         mon_bad = 0;

  initial begin : tx_monitor
    logic       prev;
    logic [7:0] b;
    bit         ab;
    bit         fr_ok;
    prev = 1'b1;
    b    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else if (prev && !TX) begin
        ab    = 1'b0;
        fr_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
          repeat ((k == 0) ? Half : B) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
          end
          if (k == 0) fr_ok = fr_ok & (TX == 1'b0);
          else if (k == 9) fr_ok = fr_ok & (TX == 1'b1);
          else b[k-1] = TX;
        end
        if (!ab) begin
          if (fr_ok) mon_q.push_back(b);
          else mon_bad++;
        end
        prev = ab ? 1'b1 : TX;
      end else begin
        prev = TX;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Send one word and check timing plus decoded bytes
  // ---------------------------------------------------------------------------
  task automatic send_word(input logic [15:0] w, input bit inject, input logic [7:0] hi,
                           input logic [7:0] lo, input string tag);
    int         j;
    bit         seen;
    logic [8:0] got;
    logic [8:0] want;
    @(negedge clk);
    check({tag, "_sent_before"}, cmd_sent, model_sent);
    cmd      = w;
    send_cmd = 1'b1;
    exp_q.push_back(hi);
    exp_q.push_back(lo);
    j    = 0;
    seen = 1'b0;
    while (!seen && j < 40 * B) begin
      @(negedge clk);
      j++;
      if (j == 1) begin
        send_cmd = 1'b0;
        check({tag, "_sent_fall"}, cmd_sent, 1'b0);
        check({tag, "_tx_idle_at_accept"}, TX, 1'b1);
      end
      if (j == 2) check({tag, "_tx_start"}, TX, 1'b0);
      // A request during the high byte must be ignored
      if (inject && j == 3 * B) begin
        cmd      = 16'hFFFF;
        send_cmd = 1'b1;
      end
      if (inject && j == 3 * B + 1) send_cmd = 1'b0;
      if (cmd_sent) seen = 1'b1;
    end
    check({tag, "_latency"}, j - 1, 20 * B + 1);
    model_sent = 1'b1;
    repeat (2 * B) @(negedge clk);
    check({tag, "_tx_idle_after"}, TX, 1'b1);
    check({tag, "_nbytes"}, mon_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      want = {1'b0, exp_q.pop_front()};
      if (mon_q.size() > 0) got = {1'b0, mon_q.pop_front()};
      else got = 9'h100;
      check({tag, "_byte"}, got, want);
    end
    mon_q.delete();
  endtask

  // Drive one 8N1 frame on RX, LSB first
  task automatic drive_rx(input logic [7:0] d, input bit stop, input string tag);
    for (int k = 0; k < 10; k++) begin
      RX = (k == 0) ? 1'b0 : (k == 9) ? stop : d[k-1];
      for (int c = 0; c < B; c++) begin
        @(negedge clk);
        if (k == 0 && c == 5) check({tag, "_rdy_clr_by_start"}, resp_rdy, 1'b0);
      end
    end
    RX = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Vector tables
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] w;
    bit          inject;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } tx_vec_t;

  typedef struct {
    logic [7:0] d;
    bit         stop;
    bit         clr_after;
    logic [7:0] exp_resp;
    bit         exp_rdy;
  } rx_vec_t;

  tx_vec_t tx_tab[4];
  rx_vec_t rx_tab[5];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : main
    logic [15:0] w;
    logic [7:0]  d;
    bit          s;

    tx_tab[0] = '{16'h1234, 1'b0, 8'h12, 8'h34};
    tx_tab[1] = '{16'hAF82, 1'b0, 8'hAF, 8'h82};
    tx_tab[2] = '{16'h5A0F, 1'b1, 8'h5A, 8'h0F};
    tx_tab[3] = '{16'h0000, 1'b0, 8'h00, 8'h00};

    rx_tab[0] = '{8'hA5, 1'b1, 1'b1, RxEn ? 8'hA5 : 8'h00, RxEn};
    rx_tab[1] = '{8'h3C, 1'b0, 1'b0, RxEn ? 8'hA5 : 8'h00, 1'b0};
    rx_tab[2] = '{8'h5A, 1'b1, 1'b0, RxEn ? 8'h5A : 8'h00, RxEn};
    rx_tab[3] = '{8'h00, 1'b1, 1'b1, 8'h00, RxEn};
    rx_tab[4] = '{8'hFF, 1'b1, 1'b0, RxEn ? 8'hFF : 8'h00, RxEn};

    rst        = 1'b1;
    cmd        = '0;
    send_cmd   = 1'b0;
    RX         = 1'b1;
    clr_rx_rdy = 1'b0;
    model_sent = 1'b0;
    m_resp     = 8'h00;
    m_rdy      = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_tx", TX, 1'b1);
    check("reset_cmd_sent", cmd_sent, 1'b0);
    check("reset_resp", resp, 8'h00);
    check("reset_resp_rdy", resp_rdy, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Transmit table
    for (int i = 0; i < 4; i++) begin
      send_word(tx_tab[i].w, tx_tab[i].inject, tx_tab[i].hi, tx_tab[i].lo,
                $sformatf("tx%0d", i));
    end

    // Receive table
    for (int i = 0; i < 5; i++) begin
      drive_rx(rx_tab[i].d, rx_tab[i].stop, $sformatf("rx%0d", i));
      rx_model(rx_tab[i].d, rx_tab[i].stop);
      check($sformatf("rx%0d_resp", i), resp, rx_tab[i].exp_resp);
      check($sformatf("rx%0d_rdy", i), resp_rdy, rx_tab[i].exp_rdy);
      if (rx_tab[i].clr_after) begin
        clr_rx_rdy = 1'b1;
        @(negedge clk);
        clr_rx_rdy = 1'b0;
        m_rdy = 1'b0;
        check($sformatf("rx%0d_rdy_after_clr", i), resp_rdy, 1'b0);
        check($sformatf("rx%0d_resp_after_clr", i), resp, rx_tab[i].exp_resp);
      end
    end

    // Random transmit words against the model
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom);
      send_word(w, 1'b0, 8'(w >> 8), 8'(w % 16'd256), $sformatf("rtx%0d", i));
    end

    // Random receive frames, occasionally with a bad stop bit
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      drive_rx(d, s, $sformatf("rrx%0d", i));
      rx_model(d, s);
      check($sformatf("rrx%0d_resp", i), resp, m_resp);
      check($sformatf("rrx%0d_rdy", i), resp_rdy, m_rdy);
    end

    // Transmit and receive at the same time
    w = 16'($urandom);
    d = 8'($urandom);
    fork
      send_word(w, 1'b0, 8'(w >> 8), 8'(w % 16'd256), "conc_tx");
      drive_rx(d, 1'b1, "conc_rx");
    join
    rx_model(d, 1'b1);
    check("conc_resp", resp, m_resp);
    check("conc_rdy", resp_rdy, m_rdy);

    // Reset in the middle of a transmit frame and a receive frame
    @(negedge clk);
    cmd      = 16'hBEEF;
    send_cmd = 1'b1;
    RX       = 1'b0;
    @(negedge clk);
    send_cmd = 1'b0;
    repeat (5 * B) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", TX, 1'b1);
    check("midrst_cmd_sent", cmd_sent, 1'b0);
    check("midrst_resp", resp, 8'h00);
    check("midrst_resp_rdy", resp_rdy, 1'b0);
    rst = 1'b0;
    RX  = 1'b1;
    repeat (12 * B) @(negedge clk);
    check("postrst_tx_idle", TX, 1'b1);
    mon_q.delete();
    exp_q.delete();
    model_sent = 1'b0;
    m_resp     = 8'h00;
    m_rdy      = 1'b0;
    send_word(16'h0F0F, 1'b0, 8'h0F, 8'h0F, "after_rst");
    drive_rx(8'h96, 1'b1, "after_rst_rx");
    rx_model(8'h96, 1'b1);
    check("after_rst_resp", resp, m_resp);
    check("after_rst_rdy", resp_rdy, m_rdy);

    check("tx_framing_errors", mon_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/remote_comm.md
REMOTE_COMM -- requirements
Module: remote_comm

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, meaning clocks per UART bit (50 MHz clk, 19200 baud).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port cmd, input, 16 bits: command word to transmit.
REQ-005 SHALL have port send_cmd, input, 1 bit: request to transmit cmd.
REQ-006 SHALL have port cmd_sent, output, 1 bit: high after both bytes are fully transmitted.
REQ-007 SHALL have port TX, output, 1 bit: serial out, idle high.
REQ-008 SHALL have port RX, input, 1 bit: asynchronous serial in, idle high.
REQ-009 SHALL have port resp, output, 8 bits: last received byte.
REQ-010 SHALL have port resp_rdy, output, 1 bit: resp holds a new byte.
REQ-011 SHALL have port clr_rx_rdy, input, 1 bit: clears resp_rdy.

Function
REQ-012 SHALL frame each UART byte as: start bit 0, then 8 data bits LSB first, then stop bit 1; each bit lasts BAUD_DIV clocks.
REQ-013 SHALL use a top-level FSM with states IDLE, SEND_HI and SEND_LO.
- IDLE -> SEND_HI on send_cmd: latch cmd; clear cmd_sent; start the byte cmd[15:8].
- SEND_HI -> SEND_LO when the high byte's stop bit ends; start cmd[7:0] in the next clock, with no extra idle time.
- SEND_LO -> IDLE when the low byte's stop bit ends; set cmd_sent in that same cycle.
REQ-014 SHALL place TX's first start-bit clock one cycle after the clock edge that samples send_cmd high.
REQ-015 SHALL ignore send_cmd outside IDLE; the latched word is unaffected by later cmd changes.
REQ-016 SHALL hold cmd_sent high until the next accepted send_cmd; cmd_sent is 0 while a transfer is in progress.
REQ-017 SHALL pass RX through a two-flop synchronizer before any use.
REQ-018 SHALL start reception on a synchronized falling edge while the receiver is idle.
REQ-019 SHALL sample each receive bit at mid-bit (BAUD_DIV/2 clocks after the start edge, then every BAUD_DIV clocks), shifting data in LSB first.
REQ-020 SHALL, when the stop-bit sample is 1, load resp and set resp_rdy in the same cycle.
REQ-021 SHALL, when the stop-bit sample is 0 (framing error), discard the byte and leave resp and resp_rdy unchanged.
REQ-022 SHALL clear resp_rdy one cycle after clr_rx_rdy is high; if a new byte completes in the same cycle, set wins.
REQ-023 SHALL clear resp_rdy when a new start bit is detected.
REQ-024 SHALL operate transmit and receive fully independently and concurrently.

Reset
REQ-025 SHALL, while rst is high, force TX=1, cmd_sent=0, resp_rdy=0, resp=8'h00, and both FSMs to idle.
REQ-026 SHALL let rst abort any frame in progress immediately; no partial byte resumes after reset.

Configuration
REQ-027 SHALL, when macro REMOTE_COMM_RX_EN is defined, include the full receive path.
REQ-028 SHALL, when REMOTE_COMM_RX_EN is undefined, omit the receive logic, tie resp=8'h00 and resp_rdy=0, and ignore RX and clr_rx_rdy.

Structure
REQ-029 SHALL place in package remote_comm_pkg: the top FSM state enum, the UART bit-FSM state enum (IDLE, START, DATA, STOP) and the default BAUD_DIV constant.
REQ-030 SHALL implement serialization and deserialization in one sub-module named uart, instantiated once.
- uart handshake: trmt/tx_data/tx_done on the transmit side.
- uart handshake: rx_rdy/rx_data/clr_rdy on the receive side.

Verification
REQ-031 SHALL check: cmd=16'h1234, send_cmd pulse -> TX carries 0x12 then 0x34; cmd_sent rises within 100000 clocks, exactly 20*BAUD_DIV+1 clocks after the accepting edge.
REQ-032 SHALL check: cmd=16'hAF82 sent after REQ-031 completes -> bytes 0xAF then 0x82; cmd_sent falls at acceptance and rises again at the end.
REQ-033 SHALL check: a second send_cmd with cmd=16'hFFFF during the high byte -> ignored; the original word is completed unchanged.
REQ-034 SHALL check: a 0xA5 frame driven on RX -> resp=8'hA5 with resp_rdy=1; clr_rx_rdy pulse -> resp_rdy=0 next cycle.
REQ-035 SHALL check: a 0x3C frame with stop bit 0 -> resp_rdy stays 0 and resp keeps its previous value.
REQ-036 SHALL check: rst asserted mid-frame -> TX=1 and cmd_sent=0 the next cycle; a new send_cmd then transmits normally.
